// File: rtl/mux_81_rr_sched_if.sv
// Bundle of request/data inputs and grant/select/sample outputs shared by the
// round-robin mux scheduler and its requester side.
interface mux_81_rr_sched_if;
    logic [7:0] req;
    logic [7:0] in;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       y;
    logic       y_valid;
    logic       busy;

    modport master (output req, in, input s, gnt, y, y_valid, busy);
    modport slave  (input req, in, output s, gnt, y, y_valid, busy);
endinterface

// File: rtl/mux_81_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters, with a bounded
// hold time per grant and a registered sample of the selected data bit.
module mux_81_rr_sched #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_81_rr_sched_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] s_r, s_s;
    logic [7:0] gnt_r, gnt_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] ptr_r, ptr_s;
    logic       busy_r;
    logic       y_r;
    logic       y_valid_r;
    logic [3:0] pick_idle_s;
    logic [3:0] pick_next_s;

    // Returns {found, index} of the first set request at or after start, wrapping.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, next-grant and hold-counter decisions.
    always_comb begin
        state_s     = state_r;
        s_s         = s_r;
        gnt_s       = gnt_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        pick_idle_s = rr_pick(bus.req, ptr_r);
        pick_next_s = rr_pick(bus.req, s_r + 3'd1);
        case (state_r)
            IDLE: begin
                if (pick_idle_s[3]) begin
                    state_s = GRANT;
                    s_s     = pick_idle_s[2:0];
                    gnt_s   = 8'd1 << pick_idle_s[2:0];
                    cnt_s   = 4'd1;
                end else begin
                    gnt_s   = 8'd0;
                end
            end
            GRANT: begin
                if (bus.req[s_r] && (cnt_r < 4'(MAX_HOLD))) begin
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    // Grant ends: advance the search origin past the outgoing owner.
                    ptr_s = s_r + 3'd1;
                    if (pick_next_s[3]) begin
                        s_s   = pick_next_s[2:0];
                        gnt_s = 8'd1 << pick_next_s[2:0];
                        cnt_s = 4'd1;
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 8'd0;
                        cnt_s   = 4'd0;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 8'd0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Scheduler state, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            s_r     <= 3'd0;
            gnt_r   <= 8'd0;
            cnt_r   <= 4'd0;
            ptr_r   <= 3'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            gnt_r   <= gnt_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
            busy_r  <= (state_s == GRANT);
        end
    end

    // Data sample of the granted input, one cycle behind the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= 1'b0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= busy_r;
            y_r       <= busy_r ? bus.in[s_r] : y_r;
        end
    end

    assign bus.s       = s_r;
    assign bus.gnt     = gnt_r;
    assign bus.busy    = busy_r;
    assign bus.y       = y_r;
    assign bus.y_valid = y_valid_r;
endmodule

// File: tb/tb_mux_81_rr_sched.sv
// Self-checking bench: two schedulers (hold limits 4 and 1) against a
// queue-free round-robin model, plus directed literal expectations.
module tb_mux_81_rr_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_v = 8'hFF;
    logic [7:0] in_v = 8'h00;
    int         checks = 0;
    int         errors = 0;

    mux_81_rr_sched_if bus4 ();
    mux_81_rr_sched_if bus1 ();
    assign bus4.req = req_v;
    assign bus4.in  = in_v;
    assign bus1.req = req_v;
    assign bus1.in  = in_v;

    mux_81_rr_sched #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    mux_81_rr_sched #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Model state per instance: 0 -> MAX_HOLD=4, 1 -> MAX_HOLD=1. owner=-1 means idle.
    int   hold_lim [2] = '{4, 1};
    int   m_ptr [2];
    int   m_own [2];
    int   m_cnt [2];
    int   m_s   [2];
    logic m_y   [2];
    logic m_yv  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_own[k] = -1; m_cnt[k] = 0;
            m_s[k] = 0; m_y[k] = 1'b0; m_yv[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [7:0] r, input logic [7:0] d);
        int j;
        m_yv[k] = (m_own[k] >= 0);
        if (m_own[k] >= 0) m_y[k] = d[m_own[k]];
        if (m_own[k] < 0) begin
            j = search(r, m_ptr[k]);
            if (j >= 0) begin m_own[k] = j; m_cnt[k] = 1; end
        end else if (r[m_own[k]] && m_cnt[k] < hold_lim[k]) begin
            m_cnt[k]++;
        end else begin
            m_ptr[k] = (m_own[k] + 1) % 8;
            j = search(r, m_ptr[k]);
            m_own[k] = j;
            m_cnt[k] = (j >= 0) ? 1 : 0;
        end
        if (m_own[k] >= 0) m_s[k] = m_own[k];
    endtask

    // Model advance on every clock edge or asynchronous reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0, req_v, in_v);
                model_step(1, req_v, in_v);
            end
        end
    end

    task automatic cmp_one(input int k, input logic [2:0] s, input logic [7:0] g,
                           input logic y, input logic yv, input logic b);
        logic [7:0] eg;
        eg = (m_own[k] >= 0) ? (8'd1 << m_own[k]) : 8'd0;
        chk($sformatf("model_gnt[%0d]", k), {24'd0, g}, {24'd0, eg});
        chk($sformatf("model_s[%0d]", k), {29'd0, s}, m_s[k]);
        chk($sformatf("model_busy[%0d]", k), {31'd0, b}, {31'd0, (m_own[k] >= 0)});
        chk($sformatf("model_yv[%0d]", k), {31'd0, yv}, {31'd0, m_yv[k]});
        chk($sformatf("model_y[%0d]", k), {31'd0, y}, {31'd0, m_y[k]});
    endtask

    // Compare both DUTs against the model away from the active edge.
    initial forever begin
        @(negedge clk);
        cmp_one(0, bus4.s, bus4.gnt, bus4.y, bus4.y_valid, bus4.busy);
        cmp_one(1, bus1.s, bus1.gnt, bus1.y, bus1.y_valid, bus1.busy);
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_v = 8'hFF;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        chk("rst_s", {29'd0, bus4.s}, 32'd0);
        chk("rst_gnt", {24'd0, bus4.gnt}, 32'd0);
        chk("rst_y", {31'd0, bus4.y}, 32'd0);
        chk("rst_yv", {31'd0, bus4.y_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus1.busy}, 32'd0);
        rst_n = 1'b1;
    endtask

    logic [7:0] tbl_req [8] = '{8'h81, 8'h3C, 8'h00, 8'hA5, 8'h10, 8'hFF, 8'h42, 8'h00};
    int         hold_exp [9] = '{0, 0, 0, 0, 7, 7, 7, 7, 0};

    initial begin
        // Single requester 3.
        do_reset();
        req_v = 8'h08; in_v = 8'h08;
        next_cycle();
        chk("single_gnt", {24'd0, bus4.gnt}, 32'h08);
        chk("single_s", {29'd0, bus4.s}, 32'd3);
        next_cycle();
        chk("single_y", {31'd0, bus4.y}, 32'd1);
        chk("single_yv", {31'd0, bus4.y_valid}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            chk("single_regrant", {24'd0, bus4.gnt}, 32'h08);
        end

        // All request, rotate every cycle.
        do_reset();
        req_v = 8'hFF; in_v = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            chk("rot_s", {29'd0, bus1.s}, c % 8);
            chk("rot_gnt", {24'd0, bus1.gnt}, 32'd1 << (c % 8));
        end

        // Hold limit between requesters 0 and 7.
        do_reset();
        req_v = 8'h81; in_v = 8'h80;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            chk("hold_s", {29'd0, bus4.s}, hold_exp[c]);
        end

        // Early drop hands over without a gap, then idle.
        do_reset();
        req_v = 8'h24; in_v = 8'h20;
        next_cycle();
        chk("drop_first", {29'd0, bus4.s}, 32'd2);
        next_cycle();
        req_v = 8'h20;
        next_cycle();
        chk("drop_s5", {29'd0, bus4.s}, 32'd5);
        chk("drop_busy", {31'd0, bus4.busy}, 32'd1);
        req_v = 8'h00;
        next_cycle();
        chk("idle_gnt", {24'd0, bus4.gnt}, 32'd0);
        chk("idle_yv_lag", {31'd0, bus4.y_valid}, 32'd1);
        chk("idle_y", {31'd0, bus4.y}, 32'd1);
        next_cycle();
        chk("idle_yv", {31'd0, bus4.y_valid}, 32'd0);

        // Async reset in the middle of a grant to 5.
        req_v = 8'h20;
        next_cycle();
        next_cycle();
        chk("pre_arst_gnt", {24'd0, bus4.gnt}, 32'h20);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", {24'd0, bus4.gnt}, 32'd0);
        chk("arst_s", {29'd0, bus4.s}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        chk("arst_regrant", {24'd0, bus4.gnt}, 32'h20);

        // Mixed request patterns checked against the model only.
        for (int t = 0; t < 8; t++) begin
            req_v = tbl_req[t];
            for (int c = 0; c < 7; c++) begin
                in_v = 8'hC3 ^ 8'(t * 37 + c * 11);
                next_cycle();
            end
        end

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
